vram_line_arbiter: RTL and testbench
====================================

Name: vram_line_arbiter

Overview:
- Shares one single-port video RAM between two requesters:
  - display line prefetch, which has priority and a hard deadline;
  - the frame loader's write stream.
- When the display side requests line N, the block issues a burst of WORDS_PER_LINE reads starting at N*WORDS_PER_LINE and streams the returned words into the line buffer.
- Between bursts, it grants the RAM port to loader writes through a valid/ready handshake.
- Sits between the pixel-position counters and timing logic, the RAM, and the line buffer. Flags missed deadlines.

Parameters:
- ADDR_WIDTH, 16, RAM word-address width.
- DATA_WIDTH, 16, RAM word width (pixels per word packed by the loader).
- WORDS_PER_LINE, 40, RAM words per display line.
- LINES, 480, number of valid line indices.
- RD_LATENCY, 2, cycles from mem_en with mem_we=0 to valid mem_rdata (>=1).
- LB_AW, $clog2(WORDS_PER_LINE), line-buffer address width.
- LINE_W, $clog2(LINES), line-index width.

Ports:
- CLK_40  in  1  clock.
- reset  in  1  synchronous, active-high.
- line_req  in  1  one-cycle pulse: fetch line line_idx.
- line_idx  in  LINE_W  line to fetch; sampled only when line_req=1.
- fetch_busy  out  1  high from the cycle after an accepted line_req until the last lb write.
- lb_wr_en  out  1  line-buffer write strobe.
- lb_wr_addr  out  LB_AW  line-buffer word index.
- lb_wr_data  out  DATA_WIDTH  line-buffer write data.
- wr_valid  in  1  loader write request.
- wr_ready  out  1  loader write accepted this cycle (combinational).
- wr_addr  in  ADDR_WIDTH  loader RAM address.
- wr_data  in  DATA_WIDTH  loader RAM data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data.
- err_clr  in  1  clears err.
- err  out  2  sticky flags: bit0 = overrun, bit1 = bad line index.

Behaviour:
- Reset values:
  - state = IDLE; all counters = 0; read-valid pipeline = 0.
  - fetch_busy, lb_wr_en, mem_en, mem_we = 0; err = 0.
  - All address and data outputs = 0.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - line_req=1 with line_idx<LINES: register base = line_idx*WORDS_PER_LINE (truncated to ADDR_WIDTH), clear rd_cnt, go to FETCH.
  - line_req=1 with line_idx>=LINES: set err[1], stay in IDLE.
- FETCH:
  - Each cycle: mem_en=1, mem_we=0, mem_addr = base+rd_cnt (registered outputs); push rd_cnt into the read-valid pipeline.
  - rd_cnt increments each cycle. After rd_cnt = WORDS_PER_LINE-1 is issued, go to DRAIN.
  - Exactly WORDS_PER_LINE reads, no gaps.
- DRAIN:
  - No reads issued.
  - Go to IDLE in the cycle after the last lb write.
- Read return path:
  - The pipeline (depth RD_LATENCY, valid + LB index) drives lb_wr_en/lb_wr_addr, with lb_wr_data = mem_rdata.
  - lb writes for index k occur exactly RD_LATENCY cycles after the read of index k.
- Loader writes:
  - wr_ready = (state!=FETCH) && !(state==IDLE && line_req) && !reset.
  - When wr_valid && wr_ready: next cycle mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - Writes are allowed in DRAIN because the port is free there.
  - One write per cycle maximum; back-to-back writes sustain 1 per cycle.
- Priority: line_req beats wr_valid in the same cycle; the write is held (wr_ready=0) and the loader keeps its request asserted.
- Overrun: line_req while state!=IDLE sets err[0]; the request is dropped and the current fetch continues unaffected.
- err:
  - Bits are sticky until err_clr.
  - err_clr has priority over a same-cycle set event (the flag stays 0).
- fetch_busy = (state!=IDLE).
- Reset mid-burst: the next cycle is idle, with no lb writes and no mem_en, even if reads are outstanding.
- Arithmetic: base and rd_cnt widths are sized so base+WORDS_PER_LINE-1 fits in ADDR_WIDTH for line_idx<LINES. This must be checked by an elaboration-time assertion.

Decomposition:
- Package vram_pkg:
  - state enum (IDLE/FETCH/DRAIN);
  - err bit-index constants;
  - default WORDS_PER_LINE/LINES/RD_LATENCY localparams.
- Sub-module rd_valid_pipe: parameterised shift register (depth RD_LATENCY, width 1+LB_AW) with synchronous clear.

Test Plan:
- Idle loader stream: wr_valid held high for 8 words at addr 0x0100..0x0107 -> mem_we=1 on 8 consecutive cycles, one cycle after each accept, with matching addr and data.
- Line fetch: line_req with line_idx=3, RAM model latency 2 -> mem_addr 120..159 on 40 consecutive cycles; lb_wr_addr 0..39 with correct data, 2 cycles after each read; fetch_busy high for 42 cycles.
- Collision: line_req and wr_valid in the same cycle -> wr_ready=0 throughout FETCH; the write is accepted in the first DRAIN cycle and lands in the RAM exactly once.
- Overrun: second line_req 10 cycles into a fetch -> err=2'b01; the first fetch completes all 40 words; err_clr returns err to 0.
- Bad index: line_req with line_idx=480 -> err=2'b10, no mem_en, state remains IDLE.
- Reset at rd_cnt=20 -> the next cycle has mem_en=0 and lb_wr_en=0, with no further lb writes; a following line_req for line 0 fetches addresses 0..39 cleanly.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM line arbiter.
package vram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Bit positions inside the sticky err vector.
  localparam int ERR_OVERRUN  = 0;
  localparam int ERR_BAD_LINE = 1;

  localparam int DEF_WORDS_PER_LINE = 40;
  localparam int DEF_LINES          = 480;
  localparam int DEF_RD_LATENCY     = 2;

endpackage

// File: rtl/vram_line_arbiter_rd_valid_pipe.sv
// Fixed-depth shift register tracking in-flight reads (valid + line-buffer index).
module rd_valid_pipe
  import vram_pkg::*;
#(
  parameter int DEPTH = DEF_RD_LATENCY,
  parameter int WIDTH = 7
) (
  input  logic             CLK_40,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one slot per cycle; clear drops everything in flight.
  always_ff @(posedge CLK_40) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vram_line_arbiter.sv
// Arbitrates one single-port VRAM between display line prefetch bursts
// (priority, hard deadline) and the frame loader's write stream.
module vram_line_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int LINES          = DEF_LINES,
  parameter int RD_LATENCY     = DEF_RD_LATENCY,
  parameter int LB_AW          = $clog2(WORDS_PER_LINE),
  parameter int LINE_W         = $clog2(LINES)
) (
  input  logic                  CLK_40,
  input  logic                  reset,
  input  logic                  line_req,
  input  logic [LINE_W-1:0]     line_idx,
  output logic                  fetch_busy,
  output logic                  lb_wr_en,
  output logic [LB_AW-1:0]      lb_wr_addr,
  output logic [DATA_WIDTH-1:0] lb_wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  err_clr,
  output logic [1:0]            err
);

  // The last word of the last valid line must be addressable.
  if (longint'(LINES) * longint'(WORDS_PER_LINE) > (longint'(1) << ADDR_WIDTH)) begin : g_addr_overflow
    $error("vram_line_arbiter: LINES*WORDS_PER_LINE exceeds the ADDR_WIDTH address space");
  end
  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("vram_line_arbiter: RD_LATENCY must be at least 1");
  end

  localparam logic [LB_AW-1:0]      LAST_IDX = LB_AW'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0] WPL_A    = ADDR_WIDTH'(WORDS_PER_LINE);

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   base, base_next, line_base;
  logic [LB_AW-1:0]        rd_cnt, rd_cnt_next;
  logic                    idx_ok, start, last_rd, last_lb, wr_fire;
  logic                    mem_en_next, mem_we_next;
  logic [ADDR_WIDTH-1:0]   mem_addr_next;
  logic [DATA_WIDTH-1:0]   mem_wdata_next;
  logic [1:0]              err_set;
  logic [LB_AW:0]          pipe_in, pipe_out;

  assign idx_ok     = (32'(line_idx) < 32'(LINES));
  assign line_base  = ADDR_WIDTH'(line_idx) * WPL_A;
  assign start      = (state == IDLE) && line_req && idx_ok;
  assign wr_ready   = (state != FETCH) && !((state == IDLE) && line_req) && !reset;
  assign wr_fire    = wr_valid && wr_ready;
  assign last_rd    = (rd_cnt == LAST_IDX);
  assign last_lb    = lb_wr_en && (lb_wr_addr == LAST_IDX);
  assign fetch_busy = (state != IDLE);

  assign err_set[ERR_OVERRUN]  = line_req && (state != IDLE);
  assign err_set[ERR_BAD_LINE] = line_req && (state == IDLE) && !idx_ok;

  // The read visible on the RAM port this cycle enters the return pipeline,
  // so its data meets the line buffer RD_LATENCY cycles later.
  assign pipe_in    = {(state == FETCH), rd_cnt};
  assign lb_wr_en   = pipe_out[LB_AW];
  assign lb_wr_addr = pipe_out[LB_AW-1:0];
  assign lb_wr_data = lb_wr_en ? mem_rdata : '0;

  rd_valid_pipe #(
    .DEPTH (RD_LATENCY),
    .WIDTH (LB_AW + 1)
  ) u_rd_valid_pipe (
    .CLK_40 (CLK_40),
    .clear  (reset),
    .din    (pipe_in),
    .dout   (pipe_out)
  );

  // Burst sequencing: next state, burst base and read counter.
  always_comb begin
    next_state  = state;
    base_next   = base;
    rd_cnt_next = rd_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          next_state  = FETCH;
          base_next   = line_base;
          rd_cnt_next = '0;
        end else begin
          next_state  = IDLE;
        end
      end
      FETCH: begin
        if (last_rd) begin
          next_state  = DRAIN;
        end else begin
          next_state  = FETCH;
          rd_cnt_next = rd_cnt + LB_AW'(1);
        end
      end
      DRAIN: begin
        if (last_lb) begin
          next_state  = IDLE;
          rd_cnt_next = '0;
        end else begin
          next_state  = DRAIN;
        end
      end
      default: begin
        next_state  = IDLE;
        rd_cnt_next = '0;
      end
    endcase
  end

  // RAM port request for the next cycle: burst reads first, loader writes in the gaps.
  // mem_addr always equals base+rd_cnt while in FETCH, so the first read is set up on entry.
  always_comb begin
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    if (start) begin
      mem_en_next   = 1'b1;
      mem_addr_next = line_base;
    end else if ((state == FETCH) && !last_rd) begin
      mem_en_next   = 1'b1;
      mem_addr_next = base + ADDR_WIDTH'(rd_cnt) + ADDR_WIDTH'(1);
    end else if (wr_fire) begin
      mem_en_next    = 1'b1;
      mem_we_next    = 1'b1;
      mem_addr_next  = wr_addr;
      mem_wdata_next = wr_data;
    end else begin
      mem_en_next = 1'b0;
    end
  end

  // Control state and registered RAM port outputs.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      rd_cnt    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= next_state;
      base      <= base_next;
      rd_cnt    <= rd_cnt_next;
      mem_en    <= mem_en_next;
      mem_we    <= mem_we_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      err <= 2'b00;
    end else if (err_clr) begin
      err <= 2'b00;
    end else begin
      err <= err | err_set;
    end
  end

endmodule

// File: tb/tb_vram_line_arbiter.sv
// Scoreboard bench for vram_line_arbiter: a cycle-level reference model queues
// expected RAM accesses and line-buffer writes; a monitor pops and compares.
module tb_vram_line_arbiter;

  localparam int AW = 16, DW = 16, WPL = 40, NL = 480, LAT = 2, LBW = 6, LW = 9;

  typedef struct { int cyc; logic we; logic [15:0] addr; logic [15:0] data; } mem_exp_t;
  typedef struct { int cyc; logic [LBW-1:0] addr; logic [15:0] data; } lb_exp_t;

  logic CLK_40 = 1'b0;
  always #12 CLK_40 = ~CLK_40;

  logic           reset, line_req, wr_valid, err_clr;
  logic [LW-1:0]  line_idx;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           fetch_busy, lb_wr_en, wr_ready, mem_en, mem_we;
  logic [LBW-1:0] lb_wr_addr;
  logic [DW-1:0]  lb_wr_data, mem_wdata, mem_rdata;
  logic [AW-1:0]  mem_addr;
  logic [1:0]     err;

  vram_line_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL), .LINES(NL), .RD_LATENCY(LAT)
  ) dut (
    .CLK_40(CLK_40), .reset(reset), .line_req(line_req), .line_idx(line_idx),
    .fetch_busy(fetch_busy), .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_clr(err_clr), .err(err)
  );

  int cyc = 0;
  always @(posedge CLK_40) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input int a);
    logic [15:0] w;
    w = a[15:0];
    return {w[7:0], w[15:8]} ^ 16'hA5C3;
  endfunction

  // RAM seen by the DUT: unwritten words read back a fixed address pattern.
  logic [15:0] ram [0:65535];
  bit          ram_wr [0:65535];
  logic [15:0] rd_pipe [LAT];
  always @(posedge CLK_40) begin
    if (mem_en && !mem_we) rd_pipe[0] <= ram_wr[mem_addr] ? ram[mem_addr] : init_word(int'(mem_addr));
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model state.
  logic [15:0] ref_ram [0:65535];
  bit          ref_wr  [0:65535];
  mem_exp_t    mem_q [$];
  lb_exp_t     lb_q  [$];
  int   n_vec = 0, n_fail = 0, busy_cnt = 0;
  int   busy_lo = 0, busy_hi = -1, fetch_lo = 0, fetch_hi = -1;
  logic chk_en = 1'b0, exp_busy = 1'b0, exp_ready = 1'b0, last_acc = 1'b0;
  logic [1:0] err_cur = 2'b00, err_nxt = 2'b00;

  function automatic logic [15:0] ref_read(input int a);
    return ref_wr[a] ? ref_ram[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic monitor_cycle();
    mem_exp_t me;
    lb_exp_t  le;
    chk("fetch_busy", int'(fetch_busy), int'(exp_busy));
    chk("wr_ready", int'(wr_ready), int'(exp_ready));
    chk("err", int'(err), int'(err_cur));
    if (fetch_busy) busy_cnt++;
    while (mem_q.size() > 0 && mem_q[0].cyc < cyc) begin
      me = mem_q.pop_front();
      n_vec++; n_fail++;
      $display("FAIL mem_missing at cycle %0d: got no access, expected we=%0b addr %0h at cycle %0d", cyc, me.we, me.addr, me.cyc);
    end
    if (mem_en) begin
      if (mem_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL mem_unexpected at cycle %0d: got we=%0b addr %0h, expected no access", cyc, mem_we, mem_addr);
      end else begin
        me = mem_q.pop_front();
        chk("mem_cycle", cyc, me.cyc);
        chk("mem_we", int'(mem_we), int'(me.we));
        chk("mem_addr", int'(mem_addr), int'(me.addr));
        if (me.we) chk("mem_wdata", int'(mem_wdata), int'(me.data));
      end
    end
    while (lb_q.size() > 0 && lb_q[0].cyc < cyc) begin
      le = lb_q.pop_front();
      n_vec++; n_fail++;
      $display("FAIL lb_missing at cycle %0d: got no write, expected addr %0d at cycle %0d", cyc, le.addr, le.cyc);
    end
    if (lb_wr_en) begin
      if (lb_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL lb_unexpected at cycle %0d: got addr %0d, expected no write", cyc, lb_wr_addr);
      end else begin
        le = lb_q.pop_front();
        chk("lb_cycle", cyc, le.cyc);
        chk("lb_addr", int'(lb_wr_addr), int'(le.addr));
        chk("lb_data", int'(lb_wr_data), int'(le.data));
      end
    end
  endtask

  // Drive one cycle of inputs and advance the reference model by one cycle.
  task automatic step(input logic rst, input logic lreq, input int lidx, input logic wv,
                      input logic [15:0] wa, input logic [15:0] wd, input logic eclr);
    logic busy, infetch;
    logic [1:0] set;
    int base;
    @(posedge CLK_40);
    #1;
    err_cur  = err_nxt;
    reset    = rst;  line_req = lreq; line_idx = LW'(lidx);
    wr_valid = wv;   wr_addr  = wa;   wr_data  = wd;  err_clr = eclr;
    busy      = (cyc >= busy_lo) && (cyc <= busy_hi);
    infetch   = (cyc >= fetch_lo) && (cyc <= fetch_hi);
    exp_busy  = busy;
    exp_ready = !rst && !infetch && !(!busy && lreq);
    last_acc  = wv && exp_ready;
    if (last_acc) begin
      mem_q.push_back('{cyc + 1, 1'b1, wa, wd});
      ref_ram[wa] = wd;
      ref_wr[wa]  = 1'b1;
    end
    set = 2'b00;
    if (rst) begin
      while (mem_q.size() > 0 && mem_q[$].cyc > cyc) void'(mem_q.pop_back());
      while (lb_q.size() > 0 && lb_q[$].cyc > cyc) void'(lb_q.pop_back());
      if (busy_hi > cyc) busy_hi = cyc;
      if (fetch_hi > cyc) fetch_hi = cyc;
      err_nxt = 2'b00;
    end else begin
      if (lreq) begin
        if (busy) set[0] = 1'b1;
        else if (lidx >= NL) set[1] = 1'b1;
        else begin
          base = lidx * WPL;
          for (int k = 0; k < WPL; k++) begin
            mem_q.push_back('{cyc + 1 + k, 1'b0, 16'(base + k), 16'h0000});
            lb_q.push_back('{cyc + 1 + k + LAT, LBW'(k), ref_read(base + k)});
          end
          fetch_lo = cyc + 1; fetch_hi = cyc + WPL;
          busy_lo  = cyc + 1; busy_hi  = cyc + WPL + LAT;
        end
      end
      err_nxt = eclr ? 2'b00 : (err_cur | set);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  initial begin
    int b0;
    logic rr, lq, wv, ec;
    int li;
    reset = 1'b1; line_req = 1'b0; line_idx = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; err_clr = 1'b0;
    fork
      forever begin
        @(negedge CLK_40);
        if (chk_en) monitor_cycle();
      end
    join_none

    step(1'b1, 1'b0, 0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_lb_wr_en", int'(lb_wr_en), 0);
    chk("rst_fetch_busy", int'(fetch_busy), 0);
    chk("rst_err", int'(err), 0);

    // Loader stream while idle: 8 back-to-back writes.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, 1'b1, 16'h0100 + 16'(i), 16'($urandom), 1'b0);
    idle(2);

    // Line 3 fetch, busy window length.
    b0 = busy_cnt;
    step(1'b0, 1'b1, 3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    idle(50);
    chk("busy_cycles", busy_cnt - b0, 42);

    // Collision: the write waits out FETCH, then is read back by a later fetch.
    step(1'b0, 1'b1, 5, 1'b1, 16'h0200, 16'hBEEF, 1'b0);
    for (int t = 0; t < 100 && !last_acc; t++) step(1'b0, 1'b0, 0, 1'b1, 16'h0200, 16'hBEEF, 1'b0);
    idle(5);
    step(1'b0, 1'b1, 12, 1'b0, 16'h0000, 16'h0000, 1'b0);
    idle(50);

    // Overrun 10 cycles into a fetch.
    step(1'b0, 1'b1, 7, 1'b0, 16'h0000, 16'h0000, 1'b0);
    idle(9);
    step(1'b0, 1'b1, 9, 1'b0, 16'h0000, 16'h0000, 1'b0);
    idle(40);
    chk("overrun_err", int'(err), 1);
    step(1'b0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    idle(1);
    chk("overrun_cleared", int'(err), 0);

    // Bad index, then clear colliding with a new set.
    step(1'b0, 1'b1, 480, 1'b0, 16'h0000, 16'h0000, 1'b0);
    idle(2);
    chk("badidx_err", int'(err), 2);
    chk("badidx_busy", int'(fetch_busy), 0);
    step(1'b0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step(1'b0, 1'b1, 500, 1'b0, 16'h0000, 16'h0000, 1'b1);
    idle(2);
    chk("clr_beats_set", int'(err), 0);

    // Reset while rd_cnt = 20, then a clean fetch of line 0.
    step(1'b0, 1'b1, 2, 1'b0, 16'h0000, 16'h0000, 1'b0);
    idle(20);
    step(1'b1, 1'b0, 0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("midrst_mem_en", int'(mem_en), 0);
    chk("midrst_lb_wr_en", int'(lb_wr_en), 0);
    idle(5);
    step(1'b0, 1'b1, 0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    idle(50);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rr = ($urandom_range(0, 399) == 0);
      lq = !rr && ($urandom_range(0, 29) == 0);
      li = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 51));
      wv = ($urandom_range(0, 1) == 1);
      ec = ($urandom_range(0, 39) == 0);
      step(rr, lq, li, wv, 16'($urandom_range(0, 2047)), 16'($urandom), ec);
    end
    idle(60);
    chk("mem_q_drained", mem_q.size(), 0);
    chk("lb_q_drained", lb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
